// File: rtl/tone_sweep_sequencer.sv
// Tone sweep sequencer: walks freq_sel through the enabled tone slots, drops the
// settling samples after each tone change and forwards a programmed dwell of samples.
module tone_sweep_sequencer #(
    parameter int NUM_TONES = 4,
    parameter int DWELL_W   = 16,
    parameter int SETTLE    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [NUM_TONES-1:0] tone_mask,
    input  logic [DWELL_W-1:0]   dwell_len,
    input  logic                 sin_valid,
    input  logic [23:0]          sin_data,
    output logic                 run,
    output logic [3:0]           freq_sel,
    output logic                 out_valid,
    output logic [23:0]          out_data,
    output logic                 tone_strobe,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_DWELL  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_TONES-1:0] mask_q, mask_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [SET_W-1:0]     set_cnt_q, set_cnt_d;
    logic [DWELL_W-1:0]   dw_cnt_q, dw_cnt_d;
    logic                 run_q, run_d;
    logic [3:0]           freq_q, freq_d;
    logic                 ov_q, ov_d;
    logic [23:0]          od_q, od_d;
    logic                 ts_q, ts_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 higher_s;

    // Next-state and next-output computation for the sweep FSM
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        dwell_d   = dwell_q;
        set_cnt_d = set_cnt_q;
        dw_cnt_d  = dw_cnt_q;
        freq_d    = freq_q;
        od_d      = od_q;
        ov_d      = 1'b0;
        ts_d      = 1'b0;
        higher_s  = |((mask_q >> idx_q) >> 1'b1);

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (tone_mask != {NUM_TONES{1'b0}})) begin
                    mask_d  = tone_mask;
                    dwell_d = (dwell_len == {DWELL_W{1'b0}}) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell_len;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                // run is low here, so the generator restarts its phase on the new tone
                if (mask_q[idx_q]) begin
                    freq_d    = 4'(idx_q);
                    set_cnt_d = {SET_W{1'b0}};
                    dw_cnt_d  = {DWELL_W{1'b0}};
                    if (SETTLE == 0) begin
                        state_d = S_DWELL;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (sin_valid) begin
                    if (set_cnt_q == SETTLE_LAST) begin
                        set_cnt_d = {SET_W{1'b0}};
                        state_d   = S_DWELL;
                    end else begin
                        set_cnt_d = set_cnt_q + 1'b1;
                    end
                end else begin
                    set_cnt_d = set_cnt_q;
                end
            end
            S_DWELL: begin
                if (sin_valid) begin
                    ov_d = 1'b1;
                    od_d = sin_data;
                    ts_d = (dw_cnt_q == {DWELL_W{1'b0}});
                    if (dw_cnt_q == dwell_q - 1'b1) begin
                        dw_cnt_d = {DWELL_W{1'b0}};
                        if (higher_s) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_SELECT;
                        end else if (loop_en) begin
                            idx_d   = {IDX_W{1'b0}};
                            state_d = S_SELECT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        dw_cnt_d = dw_cnt_q + 1'b1;
                    end
                end else begin
                    dw_cnt_d = dw_cnt_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ov_d    = 1'b0;
            ts_d    = 1'b0;
        end else begin
            ov_d = ov_d;
        end

        run_d  = (state_d == S_SETTLE) || (state_d == S_DWELL);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, latched configuration and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            mask_q    <= {NUM_TONES{1'b0}};
            dwell_q   <= {DWELL_W{1'b0}};
            set_cnt_q <= {SET_W{1'b0}};
            dw_cnt_q  <= {DWELL_W{1'b0}};
            run_q     <= 1'b0;
            freq_q    <= 4'd0;
            ov_q      <= 1'b0;
            od_q      <= 24'd0;
            ts_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            dwell_q   <= dwell_d;
            set_cnt_q <= set_cnt_d;
            dw_cnt_q  <= dw_cnt_d;
            run_q     <= run_d;
            freq_q    <= freq_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            ts_q      <= ts_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign run         = run_q;
    assign freq_sel    = freq_q;
    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign tone_strobe = ts_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tone_sweep_sequencer.sv
// Directed bench for tone_sweep_sequencer; forwarded samples are checked
// against a queue of expected {strobe, freq_sel, data} entries.
module tb_tone_sweep_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, loop_en, sin_valid;
    logic [3:0]  tone_mask;
    logic [15:0] dwell_len;
    logic [23:0] sin_data;
    logic        run, out_valid, tone_strobe, busy, done;
    logic [3:0]  freq_sel;
    logic [23:0] out_data;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_ref;
    logic [28:0] exp_q[$];

    tone_sweep_sequencer #(.NUM_TONES(4), .DWELL_W(16), .SETTLE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .tone_mask(tone_mask), .dwell_len(dwell_len), .sin_valid(sin_valid),
        .sin_data(sin_data), .run(run), .freq_sel(freq_sel), .out_valid(out_valid),
        .out_data(out_data), .tone_strobe(tone_strobe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every forwarded sample
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    logic [28:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", {8'd0, out_data}, {8'd0, e[23:0]});
                    chk("out_freq_sel", {28'd0, freq_sel}, {28'd0, e[27:24]});
                    chk("tone_strobe", {31'd0, tone_strobe}, {31'd0, e[28]});
                end
            end else if (tone_strobe) begin
                chk("strobe_without_valid", 32'd1, 32'd0);
            end
        end
    end

    task automatic wait_run;
        int t = 0;
        while (run !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("run_high", {31'd0, run}, 32'd1);
    endtask

    task automatic send(input logic [23:0] d);
        sin_valid = 1'b1;
        sin_data  = d;
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    task automatic run_tone(input logic [3:0] f, input int ndisc, input int nfwd, input logic [23:0] first_d);
        logic [23:0] d;
        wait_run();
        chk("freq_sel_tone", {28'd0, freq_sel}, {28'd0, f});
        for (int i = 0; i < ndisc; i++) send(24'($urandom));
        for (int i = 0; i < nfwd; i++) begin
            d = (i == 0) ? first_d : 24'($urandom);
            exp_q.push_back({(i == 0), f, d});
            send(d);
        end
        chk("run_low_after_tone", {31'd0, run}, 32'd0);
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [15:0] dw, input logic st);
        tone_mask = m;
        dwell_len = dw;
        start     = 1'b1;
        stop      = st;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sin_valid = 1'b0;
        tone_mask = 4'd0; dwell_len = 16'd0; sin_data = 24'd0;
        repeat (3) @(negedge clk);
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {8'd0, out_data}, 32'd0);
        chk("rst_freq_sel", {28'd0, freq_sel}, 32'd0);
        chk("rst_tone_strobe", {31'd0, tone_strobe}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Empty mask is ignored
        pulse_start(4'b0000, 16'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("mask0_busy", {31'd0, busy}, 32'd0);
        chk("mask0_run", {31'd0, run}, 32'd0);

        // start and stop together in IDLE: stop wins
        pulse_start(4'b0001, 16'd3, 1'b1);
        repeat (3) @(negedge clk);
        chk("startstop_busy", {31'd0, busy}, 32'd0);

        // Two-tone single pass
        done_ref = done_cnt;
        pulse_start(4'b0101, 16'd3, 1'b0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        run_tone(4'd0, 8, 3, 24'h7FFFFF);
        chk("no_done_mid_sweep", done_cnt, done_ref);
        run_tone(4'd2, 8, 3, 24'h800000);
        repeat (3) @(negedge clk);
        chk("sweep1_done_pulses", done_cnt, done_ref + 1);
        chk("sweep1_busy_end", {31'd0, busy}, 32'd0);
        chk("sweep1_queue_empty", exp_q.size(), 32'd0);

        // Dwell of zero forwards exactly one sample
        done_ref = done_cnt;
        pulse_start(4'b0001, 16'd0, 1'b0);
        run_tone(4'd0, 8, 1, 24'h123456);
        repeat (3) @(negedge clk);
        chk("dwell0_done_pulses", done_cnt, done_ref + 1);
        chk("dwell0_queue_empty", exp_q.size(), 32'd0);

        // Continuous looping on tone 3, aborted by stop
        done_ref = done_cnt;
        loop_en = 1'b1;
        pulse_start(4'b1000, 16'd2, 1'b0);
        for (int k = 0; k < 3; k++) run_tone(4'd3, 8, 2, 24'h000100 + 24'(k));
        wait_run();
        send(24'h0A0A0A);
        send(24'h0B0B0B);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_run", {31'd0, run}, 32'd0);
        chk("stop_out_valid", {31'd0, out_valid}, 32'd0);
        loop_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("loop_no_done", done_cnt, done_ref);
        chk("loop_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset while a DWELL sample is being captured
        pulse_start(4'b0010, 16'd4, 1'b0);
        wait_run();
        for (int i = 0; i < 8; i++) send(24'($urandom));
        sin_valid = 1'b1;
        sin_data  = 24'h55AA55;
        #1 reset = 1'b1;
        #1;
        chk("arst_run", {31'd0, run}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_freq_sel", {28'd0, freq_sel}, 32'd0);
        sin_valid = 1'b0;
        @(negedge clk);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        done_ref = done_cnt;
        pulse_start(4'b0010, 16'd1, 1'b0);
        run_tone(4'd1, 8, 1, 24'h00FFEE);
        repeat (3) @(negedge clk);
        chk("post_rst_done", done_cnt, done_ref + 1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
